// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit for the RV64 core.
//
// Holds a 64-bit program counter and a small fixed instruction ROM of
// 32-bit words. Each rising clock edge the PC either clears to zero (RESET)
// or advances by one instruction (4 bytes). The instruction at the current
// PC is presented combinationally, so each word is held for exactly one
// clock period.
//
// Parameters:
//   IMEM_WORDS  ROM depth in 32-bit words (power of two, at least 8)
//
// Ports:
//   CLOCK   input   1   sole clock, rising-edge active
//   RESET   input   1   synchronous active-high reset, clears the PC
//   OUTPUT  output  32  instruction word at the current PC
// ---------------------------------------------------------------------------
module ifu #(
    parameter int IMEM_WORDS = 64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [31:0] OUTPUT
);

    localparam int IDX_W = $clog2(IMEM_WORDS);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [63:0]      pc;
    logic [IDX_W-1:0] word_index;

    // The PC keeps counting past the end of the ROM and wraps only at the
    // 64-bit boundary; the ROM index wraps on its own because only the low
    // address bits are used.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc <= 64'd0;
        end else begin
            pc <= pc + 64'd4;
        end
    end

    // Byte address to word index; PC[1:0] is always zero and is ignored.
    assign word_index = pc[IDX_W+1:2];

    // Upper PC bits and the byte offset do not select anything in the ROM.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[63:IDX_W+2], pc[1:0]};

    // Fixed program: a short ALU test sequence followed by NOPs.
    always_comb begin
        OUTPUT = NOP_WORD;
        case (word_index)
            IDX_W'(0): OUTPUT = 32'h0050_0093;
            IDX_W'(1): OUTPUT = 32'h00A0_0113;
            IDX_W'(2): OUTPUT = 32'h0020_81B3;
            IDX_W'(3): OUTPUT = 32'h4020_8233;
            IDX_W'(4): OUTPUT = 32'h0020_F2B3;
            IDX_W'(5): OUTPUT = 32'h0020_E333;
            IDX_W'(6): OUTPUT = 32'h0020_C3B3;
            IDX_W'(7): OUTPUT = 32'h0020_9433;
            default:   OUTPUT = NOP_WORD;
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for the instruction fetch unit.
//
// A table of {reset, expected instruction} steps covers reset-then-run,
// held reset and mid-run reset; hand-written sequences cover ROM wrap and
// a reset pulse between edges; a randomized phase compares against a
// PC/ROM model built directly from the program listing.
// ---------------------------------------------------------------------------
module tb_ifu;

    localparam int IMEM_WORDS = 64;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] OUTPUT;

    int checks   = 0;
    int failures = 0;

    ifu #(.IMEM_WORDS(IMEM_WORDS)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .OUTPUT(OUTPUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        rst;
        logic [31:0] expected;
        string       name;
    } vector_t;

    vector_t vectors[$];

    // Reference model: program listing plus a byte-address PC.
    logic [31:0]     program_words[8];
    longint unsigned model_pc;

    function automatic logic [31:0] model_fetch(input longint unsigned pc);
        longint unsigned idx;
        idx = (pc / 4) % IMEM_WORDS;
        if (idx < 8) return program_words[idx];
        return 32'h0000_0013;
    endfunction

    // Drive RESET on the falling edge, then wait until just after the
    // next rising edge so the output has settled.
    task automatic applyStimulus(input logic rst);
        @(negedge CLOCK);
        RESET = rst;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expected);
        checks++;
        if (OUTPUT !== expected) begin
            failures++;
            $display("[TB] FAIL %s: OUTPUT=%08h expected=%08h", name, OUTPUT, expected);
        end
    endtask

    initial begin
        program_words[0] = 32'h0050_0093;
        program_words[1] = 32'h00A0_0113;
        program_words[2] = 32'h0020_81B3;
        program_words[3] = 32'h4020_8233;
        program_words[4] = 32'h0020_F2B3;
        program_words[5] = 32'h0020_E333;
        program_words[6] = 32'h0020_C3B3;
        program_words[7] = 32'h0020_9433;

        // Reset then run through the program into the NOP region.
        vectors.push_back('{1'b1, 32'h0050_0093, "run_reset"});
        vectors.push_back('{1'b0, 32'h00A0_0113, "run_1"});
        vectors.push_back('{1'b0, 32'h0020_81B3, "run_2"});
        vectors.push_back('{1'b0, 32'h4020_8233, "run_3"});
        vectors.push_back('{1'b0, 32'h0020_F2B3, "run_4"});
        vectors.push_back('{1'b0, 32'h0020_E333, "run_5"});
        vectors.push_back('{1'b0, 32'h0020_C3B3, "run_6"});
        vectors.push_back('{1'b0, 32'h0020_9433, "run_7"});
        vectors.push_back('{1'b0, 32'h0000_0013, "run_8_nop"});
        vectors.push_back('{1'b0, 32'h0000_0013, "run_9_nop"});
        // Reset held for five edges.
        for (int i = 0; i < 5; i++)
            vectors.push_back('{1'b1, 32'h0050_0093, "held_reset"});
        // Release, three advances, then a one-edge mid-run reset.
        vectors.push_back('{1'b0, 32'h00A0_0113, "release_1"});
        vectors.push_back('{1'b0, 32'h0020_81B3, "release_2"});
        vectors.push_back('{1'b0, 32'h4020_8233, "release_3"});
        vectors.push_back('{1'b1, 32'h0050_0093, "mid_reset"});
        vectors.push_back('{1'b0, 32'h00A0_0113, "after_mid_reset"});

        RESET = 1'b0;

        // Pre-reset: output is undefined, nothing to check yet.
        applyStimulus(1'b0);
        applyStimulus(1'b0);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].rst);
            checkOutput(vectors[i].name, vectors[i].expected);
        end

        // ROM wrap: after 64 advances the PC is 256 and word 0 returns.
        applyStimulus(1'b1);
        for (int i = 1; i <= 65; i++) begin
            applyStimulus(1'b0);
            if (i == 8)  checkOutput("wrap_nop_start", 32'h0000_0013);
            if (i == 63) checkOutput("wrap_last_word", 32'h0000_0013);
            if (i == 64) checkOutput("wrap_word0", 32'h0050_0093);
            if (i == 65) checkOutput("wrap_word1", 32'h00A0_0113);
        end

        // Reset pulse entirely between edges must not disturb the PC.
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("pulse_before", 32'h00A0_0113);
        #2 RESET = 1'b1;
        #1 RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        checkOutput("pulse_immune_1", 32'h0020_81B3);
        applyStimulus(1'b0);
        checkOutput("pulse_immune_2", 32'h4020_8233);

        // Randomized reset pattern against the model.
        applyStimulus(1'b1);
        model_pc = 0;
        checkOutput("rand_start", model_fetch(model_pc));
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 15) == 0);
            applyStimulus(r);
            if (r) model_pc = 0;
            else   model_pc = model_pc + 4;
            checkOutput("rand", model_fetch(model_pc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
